spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
SPI Flash target (mode 0, MSB first) that answers the SoC SPI master interface. It oversamples spi_sck, spi_cs_n and spi_mosi in the clk domain and decodes a minimal command set. It serves read data from a byte-wide memory read port. Used as the chip-side flash model in system benches and as a synthesizable boot-flash emulator on FPGA.

Parameters:
ADDR_W, 24, memory index width (1..24); upper received address bits are dropped.
JEDEC_ID, 24'hEF4018, 3-byte ID returned by command 0x9F, MSB byte first.
SYNC_STAGES, 2, synchronizer depth on spi_cs_n/spi_sck/spi_mosi (minimum 2).

Ports:
clk  input  1  system clock; must be at least 8x the spi_sck frequency
rst  input  1  asynchronous reset, active-high
spi_cs_n  input  1  chip select from master, active-low
spi_sck  input  1  SPI clock from master, idle low
spi_mosi  input  1  master-to-target data
spi_miso  output  1  target-to-master data
spi_miso_oe  output  1  output enable, 1 only while a response phase is active
mem_req  output  1  single-cycle read strobe
mem_addr  output  ADDR_W  byte address qualified by mem_req
mem_rdata  input  8  read data, valid exactly 1 clk after mem_req
busy  output  1  1 while synchronized cs_n is low and the block is armed
cmd_err  output  1  1-clk pulse when an unsupported opcode completes
last_cmd  output  8  most recent opcode received, held until the next opcode

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; armed=0. Decoding stays blocked until synchronized cs_n is first seen high after reset (no mid-frame decode).
- Edge detect: the synchronized sck is delayed one more flop. Rise = 0->1, fall = 1->0. spi_mosi is sampled on rise. spi_miso changes only on fall.
- Synchronized cs_n high: state IDLE, bit counter 0, spi_miso=0, spi_miso_oe=0, busy=0. Applies from any state, including mid-byte.
- FSM states: IDLE, CMD, ADDR, DUMMY, READ, ID, STAT, IGNORE.
- IDLE -> CMD on synchronized cs_n falling while armed.
- CMD: 8 rises shift in the opcode. After the 8th rise: last_cmd updates and the next state is decoded:
  - 0x03 -> ADDR
  - 0x9F -> ID
  - 0x05 -> STAT
  - any other opcode -> IGNORE, with cmd_err pulsing in the same clk.
- ADDR: 24 rises. On the clk after the 24th rise: mem_req=1, mem_addr=addr[ADDR_W-1:0]. On the following clk, mem_rdata is loaded into the TX shift register. State -> READ (or DUMMY, see the optional feature).
- READ:
  - On the first fall: spi_miso_oe=1 and spi_miso=byte[7].
  - Each later fall shifts out the next bit.
  - On the rise that samples bit 7 of a byte, the address increments and the next byte is prefetched with mem_req.
  - The fall after bit 0 drives bit 7 of the prefetched byte.
  - The address wraps modulo 2^ADDR_W. The stream is unbounded until cs_n rises.
- ID: returns JEDEC_ID[23:16], [15:8], [7:0], then 0xFF for every further byte. Same fall timing as READ.
- STAT: returns 0x00 repeatedly (never busy, never write-enabled).
- IGNORE: spi_miso=0, spi_miso_oe=0; remains until cs_n rises.
- Timing budget: the prefetch completes in 2 clks, and half an sck period is at least 4 clks, so data is always ready before the fall that uses it.
- A simultaneous rise and cs_n deassert in the same clk: cs_n wins and the block returns to IDLE.

Optional Feature:
SPI_FAST_READ_EN:
- When defined, opcode 0x0B is accepted: ADDR, then DUMMY (8 rises, spi_miso_oe=0), then READ.
- The prefetch is issued at the end of ADDR.
- The first data bit is driven on the fall after the 8th dummy rise.
- Undefined: 0x0B is unsupported, so it gives cmd_err and IGNORE.

Test Plan:
1. Read 0x03, address 0x000010, 4 bytes. Memory model returns addr[7:0]^8'hA5. Expected: MISO bytes 0xB5, 0xB4, 0xB7, 0xB6; mem_addr 0x10..0x13; each mem_req is 1 clk.
2. JEDEC 0x9F, 5 bytes. Expected: 0xEF, 0x40, 0x18, 0xFF, 0xFF; last_cmd=0x9F; cmd_err never pulses.
3. Opcode 0xAB followed by 16 clocks. Expected: one cmd_err pulse after the 8th rise; spi_miso=0 and spi_miso_oe=0 throughout; last_cmd=0xAB.
4. With ADDR_W=8, read 0x03 at address 0x0000FF, 2 bytes. Expected: mem_addr 0xFF then 0x00.
5. cs_n rises after 3 opcode bits, then a full 0x05 transaction. Expected: the partial frame is discarded; the new frame returns 0x00, 0x00; busy=0 while cs_n is high.
6. rst pulsed during a read with cs_n held low, then 16 more sck cycles. Expected: outputs 0 and no mem_req. After cs_n goes high then low, a 0x9F transaction returns 0xEF. With SPI_FAST_READ_EN defined: 0x0B, address 0x10, 8 dummy cycles. Expected: first byte 0xB5.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI flash target (mode 0, MSB first) oversampled in the clk domain.
// Commands: 0x03 read, 0x9F JEDEC ID, 0x05 status. Read data comes from a
// byte-wide memory port with one clk of latency.
// Optional: define SPI_FAST_READ_EN to accept 0x0B (read with 8 dummy clocks).
module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err,
    output logic [7:0]        last_cmd
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_ID, S_STAT, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic cs_s, sck_s, mosi_s, rise, fall;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [22:0]       sh_q, sh_d;
    logic [23:0]       sh_shift;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        buf_q, buf_d;
    logic [7:0]        tx_q, tx_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              fast_q, fast_d;
    logic              armed_q, armed_d;
    logic              cs_dly_q, cs_dly_d;
    logic              sck_dly_q, sck_dly_d;
    logic              rvalid_q, rvalid_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              mem_req_q, mem_req_d;
    logic              cmd_err_q, cmd_err_d;
    logic [7:0]        last_cmd_q, last_cmd_d;

    // Synchronize the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign rise     = sck_s & ~sck_dly_q;
    assign fall     = ~sck_s & sck_dly_q;
    assign sh_shift = {sh_q, mosi_s};

    // Next-state logic: command decode, address capture, prefetch and MISO shifting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        tx_d       = tx_q;
        id_idx_d   = id_idx_q;
        fast_d     = fast_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        last_cmd_d = last_cmd_q;
        mem_req_d  = 1'b0;
        cmd_err_d  = 1'b0;
        rvalid_d   = mem_req_q;
        armed_d    = armed_q | cs_s;
        cs_dly_d   = cs_s;
        sck_dly_d  = sck_s;

        // Memory data arrives one clk after the strobe; park it as the next byte.
        if (rvalid_q) begin
            buf_d = mem_rdata;
        end

        if (cs_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fcnt_d  = '0;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_dly_q && armed_q) begin
                        state_d = S_CMD;
                        cnt_d   = '0;
                    end
                end
                S_CMD: begin
                    if (rise) begin
                        sh_d  = sh_shift[22:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d      = '0;
                            fcnt_d     = '0;
                            fast_d     = 1'b0;
                            last_cmd_d = sh_shift[7:0];
                            case (sh_shift[7:0])
                                8'h03: state_d = S_ADDR;
                                8'h9F: begin
                                    state_d  = S_ID;
                                    buf_d    = JEDEC_ID[23:16];
                                    id_idx_d = 2'd1;
                                end
                                8'h05: begin
                                    state_d = S_STAT;
                                    buf_d   = '0;
                                end
`ifdef SPI_FAST_READ_EN
                                8'h0B: begin
                                    state_d = S_ADDR;
                                    fast_d  = 1'b1;
                                end
`endif
                                default: begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        sh_d  = sh_shift[22:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d     = '0;
                            fcnt_d    = '0;
                            addr_d    = sh_shift[ADDR_W-1:0];
                            mem_req_d = 1'b1;
                            state_d   = fast_q ? S_DUMMY : S_READ;
                        end
                    end
                end
                S_DUMMY: begin
                    if (rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            fcnt_d  = '0;
                            state_d = S_READ;
                        end
                    end
                end
                S_READ, S_ID, S_STAT: begin
                    // First fall of a byte takes the parked byte; later falls shift.
                    if (fall) begin
                        oe_d   = 1'b1;
                        fcnt_d = fcnt_q + 3'd1;
                        if (fcnt_q == 3'd0) begin
                            miso_d = buf_q[7];
                            tx_d   = {buf_q[6:0], 1'b0};
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                    // The rise sampling bit 7 frees the parked byte for the next one.
                    if (rise && fcnt_q == 3'd1) begin
                        if (state_q == S_READ) begin
                            addr_d    = addr_q + ADDR_W'(1);
                            mem_req_d = 1'b1;
                        end else if (state_q == S_ID) begin
                            case (id_idx_q)
                                2'd1:    buf_d = JEDEC_ID[15:8];
                                2'd2:    buf_d = JEDEC_ID[7:0];
                                default: buf_d = 8'hFF;
                            endcase
                            if (id_idx_q != 2'd3) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                        end else begin
                            buf_d = '0;
                        end
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            tx_q       <= '0;
            id_idx_q   <= '0;
            fast_q     <= 1'b0;
            armed_q    <= 1'b0;
            cs_dly_q   <= 1'b0;
            sck_dly_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            last_cmd_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            tx_q       <= tx_d;
            id_idx_q   <= id_idx_d;
            fast_q     <= fast_d;
            armed_q    <= armed_d;
            cs_dly_q   <= cs_dly_d;
            sck_dly_q  <= sck_dly_d;
            rvalid_q   <= rvalid_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            mem_req_q  <= mem_req_d;
            cmd_err_q  <= cmd_err_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign cmd_err     = cmd_err_q;
    assign last_cmd    = last_cmd_q;
    assign busy        = ~cs_s & armed_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a bit-banged SPI master drives two instances
// (ADDR_W=24 and ADDR_W=8) on a shared bus; captured bytes are compared
// against a flash behaviour model and hand-computed values.
module tb_spi_flash_responder;

    localparam int          HALF  = 80;
    localparam logic [23:0] JEDEC = 24'hEF4018;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;

    logic        spi_miso, spi_miso_oe, mem_req, busy, cmd_err;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata, last_cmd;

    logic        miso8, oe8, req8, busy8, err8;
    logic [7:0]  addr8, rdata8, last8;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int cs_hi_cnt = 0;
    bit quiet = 1'b0;
    bit noreq = 1'b0;
    logic prev_req = 1'b0, prev_err = 1'b0;

    logic [23:0] log24[$];
    logic [7:0]  log8[$];
    logic [7:0]  rxq[$], rxq8[$];

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(JEDEC), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err), .last_cmd(last_cmd)
    );

    spi_flash_responder #(.ADDR_W(8), .JEDEC_ID(JEDEC), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .mem_req(req8), .mem_addr(addr8),
        .mem_rdata(rdata8), .busy(busy8), .cmd_err(err8), .last_cmd(last8)
    );

    // Memories: data = addr[7:0]^A5, valid only the clk after the strobe.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? (mem_addr[7:0] ^ 8'hA5) : 8'h3C;
        rdata8    <= req8 ? (addr8 ^ 8'hA5) : 8'h3C;
        if (mem_req) log24.push_back(mem_addr);
        if (req8) log8.push_back(addr8);
        if (cmd_err) err_pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash behaviour: expected i-th response byte of a frame.
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr,
                                              input int unsigned aw, input int unsigned i);
        logic [23:0] a;
        logic [23:0] id;
        id = JEDEC;
        case (op)
            8'h03: begin
                a = addr + 24'(i);
                if (aw < 24) a = a & ((24'd1 << aw) - 24'd1);
                return a[7:0] ^ 8'hA5;
            end
`ifdef SPI_FAST_READ_EN
            8'h0B: begin
                a = addr + 24'(i);
                if (aw < 24) a = a & ((24'd1 << aw) - 24'd1);
                return a[7:0] ^ 8'hA5;
            end
`endif
            8'h9F: begin
                if (i < 3) return 8'(id >> (8 * (2 - i)));
                return 8'hFF;
            end
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle invariants on the DUT outputs.
    always @(negedge clk) begin
        if (spi_cs_n) cs_hi_cnt++; else cs_hi_cnt = 0;
        if (rst) begin
            chk("reset_outputs", {27'd0, spi_miso, spi_miso_oe, mem_req, cmd_err, busy}, 32'd0);
        end else begin
            if (mem_req) chk("mem_req_one_clk", {31'd0, prev_req}, 32'd0);
            if (cmd_err) chk("cmd_err_one_clk", {31'd0, prev_err}, 32'd0);
            if (!spi_miso_oe) chk("miso_low_when_not_driven", {31'd0, spi_miso}, 32'd0);
            if (cs_hi_cnt >= 6)
                chk("idle_when_cs_high", {29'd0, busy, spi_miso_oe, spi_miso}, 32'd0);
            if (quiet) chk("quiet_miso_oe", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
            if (noreq) chk("unarmed_no_req_busy", {30'd0, mem_req, busy}, 32'd0);
        end
        prev_req = mem_req;
        prev_err = cmd_err;
    end

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx8);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #(HALF);
            spi_sck = 1'b1;
            rx[i]  = spi_miso;
            rx8[i] = miso8;
            #(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] op, input bit with_addr, input logic [23:0] addr,
                         input int unsigned ndummy, input int unsigned nbytes);
        logic [7:0] r, r8;
        rxq.delete();
        rxq8.delete();
        spi_cs_n = 1'b0;
        #40;
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        xfer(op, r, r8);
        if (with_addr) begin
            xfer(addr[23:16], r, r8);
            xfer(addr[15:8], r, r8);
            xfer(addr[7:0], r, r8);
        end
        for (int unsigned d = 0; d < ndummy; d++) xfer(8'h00, r, r8);
        for (int unsigned b = 0; b < nbytes; b++) begin
            xfer(8'h00, r, r8);
            rxq.push_back(r);
            rxq8.push_back(r8);
        end
        #40;
        spi_cs_n = 1'b1;
        #120;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n24, n8, e0;
        logic [7:0] r, r8;
        logic [7:0] exp1[4];
        logic [7:0] exp2[5];
        exp1 = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        exp2 = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};

        @(negedge clk);
        #2;
        #30;
        chk("reset_state", {spi_miso, spi_miso_oe, mem_req, cmd_err, busy, last_cmd, mem_addr},
            32'd0);
        rst = 1'b0;
        #100;

        // 1: read 0x03 @0x10, 4 bytes
        n24 = log24.size();
        e0  = err_pulses;
        frame(8'h03, 1'b1, 24'h000010, 0, 4);
        for (int i = 0; i < 4; i++) chk("read_byte", {24'd0, rxq[i]}, {24'd0, exp1[i]});
        chk("read_req_count", log24.size() - n24, 5);
        for (int i = 0; i < 4; i++)
            chk("read_mem_addr", {8'd0, log24[n24 + i]}, 32'h10 + 32'(i));
        chk("read_no_cmd_err", err_pulses - e0, 0);
        chk("read_last_cmd", {24'd0, last_cmd}, 32'h03);

        // 2: JEDEC ID, 5 bytes
        e0 = err_pulses;
        frame(8'h9F, 1'b0, 24'h0, 0, 5);
        for (int i = 0; i < 5; i++) chk("jedec_byte", {24'd0, rxq[i]}, {24'd0, exp2[i]});
        chk("jedec_last_cmd", {24'd0, last_cmd}, 32'h9F);
        chk("jedec_no_cmd_err", err_pulses - e0, 0);

        // 3: unsupported opcode 0xAB, then 16 clocks
        e0    = err_pulses;
        quiet = 1'b1;
        frame(8'hAB, 1'b0, 24'h0, 0, 2);
        quiet = 1'b0;
        for (int i = 0; i < 2; i++)
            chk("ignore_byte", {24'd0, rxq[i]}, {24'd0, model_byte(8'hAB, 24'h0, 24, i)});
        chk("ignore_cmd_err_pulses", err_pulses - e0, 1);
        chk("ignore_last_cmd", {24'd0, last_cmd}, 32'hAB);

        // 4: wrap at 0xFF (ADDR_W=8 instance and 24-bit instance)
        n24 = log24.size();
        n8  = log8.size();
        frame(8'h03, 1'b1, 24'h0000FF, 0, 2);
        chk("wrap8_addr0", {24'd0, log8[n8]}, 32'hFF);
        chk("wrap8_addr1", {24'd0, log8[n8 + 1]}, 32'h00);
        chk("wide_addr1", {8'd0, log24[n24 + 1]}, 32'h100);
        for (int i = 0; i < 2; i++) begin
            chk("wrap8_byte", {24'd0, rxq8[i]}, {24'd0, model_byte(8'h03, 24'hFF, 8, i)});
            chk("wide_byte", {24'd0, rxq[i]}, {24'd0, model_byte(8'h03, 24'hFF, 24, i)});
        end

        // 5: partial frame discarded, then status read
        spi_cs_n = 1'b0;
        #40;
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            #(HALF);
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
        #40;
        spi_cs_n = 1'b1;
        #100;
        chk("busy_cs_high", {31'd0, busy}, 32'd0);
        frame(8'h05, 1'b0, 24'h0, 0, 2);
        for (int i = 0; i < 2; i++)
            chk("status_byte", {24'd0, rxq[i]}, {24'd0, model_byte(8'h05, 24'h0, 24, i)});
        chk("status_last_cmd", {24'd0, last_cmd}, 32'h05);

        // 6: reset mid-read with cs_n held low
        spi_cs_n = 1'b0;
        #40;
        xfer(8'h03, r, r8);
        xfer(8'h00, r, r8);
        xfer(8'h00, r, r8);
        xfer(8'h10, r, r8);
        xfer(8'h00, r, r8);
        chk("pre_reset_byte", {24'd0, r}, {24'd0, model_byte(8'h03, 24'h10, 24, 0)});
        #40;
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #10;
        quiet = 1'b1;
        noreq = 1'b1;
        n24   = log24.size();
        e0    = err_pulses;
        for (int i = 0; i < 2; i++) begin
            xfer(8'h9F, r, r8);
            chk("post_reset_byte", {24'd0, r}, 32'd0);
        end
        chk("post_reset_no_req", log24.size() - n24, 0);
        chk("post_reset_no_err", err_pulses - e0, 0);
        chk("post_reset_last_cmd", {24'd0, last_cmd}, 32'd0);
        #40;
        spi_cs_n = 1'b1;
        #120;
        quiet = 1'b0;
        noreq = 1'b0;
        frame(8'h9F, 1'b0, 24'h0, 0, 1);
        chk("rearm_jedec", {24'd0, rxq[0]}, 32'hEF);

        // Fast read 0x0B
        e0 = err_pulses;
`ifdef SPI_FAST_READ_EN
        frame(8'h0B, 1'b1, 24'h000010, 1, 1);
        chk("fast_read_byte", {24'd0, rxq[0]}, 32'hB5);
        chk("fast_no_cmd_err", err_pulses - e0, 0);
`else
        quiet = 1'b1;
        frame(8'h0B, 1'b1, 24'h000010, 1, 1);
        quiet = 1'b0;
        chk("fast_unsupported_byte", {24'd0, rxq[0]}, {24'd0, model_byte(8'h0B, 24'h10, 24, 0)});
        chk("fast_unsupported_err", err_pulses - e0, 1);
`endif
        chk("fast_last_cmd", {24'd0, last_cmd}, 32'h0B);

        #100;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
